poll_mac: RTL
=============

// Module: poll_mac
// PURPOSE
//  Parametrised, pipelined multiply-add: OUT = A*B + C, with valid/ready handshakes on both sides.
//  Optional frame-accumulate mode sums ACC_LEN consecutive A*B+C results into one output word.
//  Next-generation Poll datapath; sits between the sample source and the readout/packing logic.
// PARAMETERS
//  WIDTH    8    operand width of A, B and C (unsigned); package default is pkg Const
//  ACC_LEN  4    samples per frame in accumulate mode; must be >= 2 and a power of 2
//  OUT_W    2*WIDTH+$clog2(ACC_LEN)  result width (derived; do not override)
// PORTS
//  clk        in   1      single clock, all logic on posedge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      A/B/C/mode valid this cycle
//  in_ready   out  1      block accepts a sample this cycle
//  mode       in   1      0 = MODE_MAC (per sample), 1 = MODE_ACC (per frame)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  c          in   WIDTH  addend C
//  out_valid  out  1      out_data valid
//  out_ready  in   1      downstream accepts out_data
//  out_data   out  OUT_W  result
//  out_last   out  1      result closes a frame (always 1 in MODE_MAC)
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_last=0, all stage valids/acc/frame counter cleared;
//    in_ready=1 in the first cycle after reset. Reset mid-frame discards the partial frame.
//  - Sample accepted when in_valid & in_ready. adv = !out_valid | out_ready; in_ready = adv.
//    All three stages advance only on adv (global stall); no data loss, no duplicates.
//  - Pipeline: S1 registers a,b,c,mode,last; S2 registers p=a*b and c; S3 = output register.
//    Latency: sample accepted at cycle t -> out_valid at t+3 when no stall occurs.
//  - MODE_MAC: out_data = p + c, zero-extended to OUT_W; out_last=1.
//  - MODE_ACC: frame counter (0..ACC_LEN-1) counts accepted samples. mode is latched when
//    counter==0; mode changes mid-frame are ignored until the next frame start.
//    Non-last samples: acc <= acc + p + c at S3, no out_valid. Last sample (counter==ACC_LEN-1):
//    out_data = acc + p + c, out_last=1, out_valid=1, acc <= 0 in the same cycle.
//  - Bubbles (in_valid=0) inside a frame are allowed; they do not advance the counter.
//  - Width: all arithmetic unsigned. OUT_W holds ACC_LEN*(2^WIDTH-1)*2^WIDTH, so no overflow
//    and no saturation logic.
//  - Back-to-back frames and mode switches at frame boundaries: zero dead cycles.
//  - out_data/out_last stay stable while out_valid & !out_ready.
// STRUCTURE
//  - pkg poll_mac_pkg: Const (default WIDTH), typedef enum logic {MODE_MAC, MODE_ACC} mode_e,
//    function out_w(width, acc_len).
//  - Sub-module poll_frame_ctr: frame counter + mode latch, outputs cur_mode and last flag.
//    Datapath stages and handshakes stay in poll_mac.
// TESTING (WIDTH=8, ACC_LEN=4)
//  1 MAC: a=3,b=4,c=5 accepted at t0, out_ready=1 -> out_valid at t0+3, out_data=17, out_last=1.
//  2 MAC max: a=b=c=255 -> out_data=65280; then 3 back-to-back samples -> 3 consecutive outputs.
//  3 ACC: (1,2,0),(3,4,1),(5,6,2),(7,8,3) -> one output, 106, out_last=1, 3 cycles after 4th;
//    4x(255,255,255) -> 261120 (18-bit, no wrap).
//  4 Stall: out_ready=0 for 5 cycles while streaming -> in_ready=0, out_data held;
//    release -> all results in order, none lost or repeated.
//  5 mode 1->0 after 2nd sample of a frame -> frame still accumulates 4 samples; next frame is MAC.
//  6 rst=1 for 1 cycle after 2 ACC samples -> outputs 0; next 4 samples give a fresh frame sum.

Source files
------------

// File: rtl/poll_mac_pkg.sv
// Shared constants, mode encoding and result-width helper for the Poll multiply-add datapath.
package poll_mac_pkg;

  localparam int unsigned Const = 8;

  typedef enum logic {
    MODE_MAC = 1'b0,
    MODE_ACC = 1'b1
  } mode_e;

  function automatic int unsigned out_w(input int unsigned width, input int unsigned acc_len);
    return 2 * width + $clog2(acc_len);
  endfunction

endpackage

// File: rtl/poll_frame_ctr.sv
// Frame sample counter and per-frame mode latch; flags the sample that closes a frame.
module poll_frame_ctr
  import poll_mac_pkg::*;
#(
  parameter int unsigned ACC_LEN = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  accept,
  input  mode_e mode,
  output mode_e cur_mode,
  output logic  last
);

  localparam int unsigned CW = $clog2(ACC_LEN);

  logic [CW-1:0] cnt;
  mode_e         frame_mode;

  // The live mode input only matters at a frame start; afterwards the latched copy rules.
  always_comb begin
    cur_mode = (cnt == '0) ? mode : frame_mode;
    last     = (cur_mode == MODE_MAC) || (cnt == CW'(ACC_LEN - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      frame_mode <= MODE_MAC;
    end else if (accept) begin
      if (cnt == '0) begin
        frame_mode <= mode;
      end
      if (cur_mode == MODE_ACC) begin
        cnt <= last ? '0 : cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/poll_mac.sv
// Three-stage pipelined OUT = A*B + C with optional per-frame accumulation and a global stall.
module poll_mac
  import poll_mac_pkg::*;
#(
  parameter int unsigned WIDTH   = Const,
  parameter int unsigned ACC_LEN = 4,
  parameter int unsigned OUT_W   = out_w(WIDTH, ACC_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last
);

  logic  adv;
  logic  accept;
  mode_e cur_mode;
  logic  frame_last;

  logic             s1_v;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] s1_c;
  mode_e            s1_mode;
  logic             s1_last;

  logic               s2_v;
  logic [2*WIDTH-1:0] s2_p;
  logic [WIDTH-1:0]   s2_c;
  mode_e              s2_mode;
  logic               s2_last;

  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] sum;

  always_comb begin
    adv      = !out_valid || out_ready;
    in_ready = adv;
    accept   = in_valid && adv;
    sum      = OUT_W'(s2_p) + OUT_W'(s2_c);
  end

  poll_frame_ctr #(
    .ACC_LEN(ACC_LEN)
  ) u_frame_ctr (
    .clk     (clk),
    .rst     (rst),
    .accept  (accept),
    .mode    (mode_e'(mode)),
    .cur_mode(cur_mode),
    .last    (frame_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_c    <= '0;
      s1_mode <= MODE_MAC;
      s1_last <= 1'b0;
    end else if (adv) begin
      s1_v <= accept;
      if (accept) begin
        s1_a    <= a;
        s1_b    <= b;
        s1_c    <= c;
        s1_mode <= cur_mode;
        s1_last <= frame_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v    <= 1'b0;
      s2_p    <= '0;
      s2_c    <= '0;
      s2_mode <= MODE_MAC;
      s2_last <= 1'b0;
    end else if (adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_p    <= s1_a * s1_b;
        s2_c    <= s1_c;
        s2_mode <= s1_mode;
        s2_last <= s1_last;
      end
    end
  end

  // Non-closing frame samples fold into acc without presenting an output word.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      acc       <= '0;
    end else if (adv) begin
      out_valid <= 1'b0;
      if (s2_v) begin
        if (s2_mode == MODE_MAC) begin
          out_valid <= 1'b1;
          out_data  <= sum;
          out_last  <= 1'b1;
        end else if (s2_last) begin
          out_valid <= 1'b1;
          out_data  <= acc + sum;
          out_last  <= 1'b1;
          acc       <= '0;
        end else begin
          acc <= acc + sum;
        end
      end
    end
  end

endmodule
